// File: rtl/slave_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack memory slave among N_MST masters.
// The winner's command is latched, driven through the slave handshake, then acknowledged back to that master.
module slave_arbiter #(
  parameter  int N_MST = 4,
  localparam int GW    = $clog2(N_MST)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_MST-1:0]       m_req_i,
  input  logic [N_MST-1:0]       m_cmd_i,
  input  logic [N_MST-1:0][31:0] m_addr_i,
  input  logic [N_MST-1:0][31:0] m_wdata_i,
  output logic [N_MST-1:0]       m_ack_o,
  output logic [N_MST-1:0][31:0] m_rdata_o,
  output logic                   s_req_o,
  output logic                   s_cmd_o,
  output logic [31:0]            s_addr_o,
  output logic [31:0]            s_wdata_o,
  input  logic                   s_ack_i,
  input  logic [31:0]            s_rdata_i,
  output logic [GW-1:0]          grant_id_o,
  output logic                   busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    S_WAIT,
    S_CAP,
    S_DROP,
    S_DONE
  } state_e;

  state_e                   state_q;
  logic [GW-1:0]            grant_q;
  logic [N_MST-1:0]         m_ack_q;
  logic [N_MST-1:0][31:0]   m_rdata_q;
  logic                     s_req_q;
  logic                     s_cmd_q;
  logic [31:0]              s_addr_q;
  logic [31:0]              s_wdata_q;
  logic                     busy_q;

  logic [GW-1:0]            winner_d;
  logic                     found_d;
  logic [GW:0]              idx;

  // Search starts one past the last grant and wraps, so a held request can never be starved.
  always_comb begin
    winner_d = grant_q;
    found_d  = 1'b0;
    idx      = '0;
    for (int i = 1; i <= N_MST; i++) begin
      idx = {1'b0, grant_q} + (GW+1)'(i);
      if (idx >= (GW+1)'(N_MST)) begin
        idx = idx - (GW+1)'(N_MST);
      end
      if (!found_d && m_req_i[idx[GW-1:0]]) begin
        found_d  = 1'b1;
        winner_d = idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      grant_q   <= GW'(N_MST-1);
      m_ack_q   <= '0;
      m_rdata_q <= '0;
      s_req_q   <= 1'b0;
      s_cmd_q   <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q   <= winner_d;
            s_cmd_q   <= m_cmd_i[winner_d];
            s_addr_q  <= m_addr_i[winner_d];
            s_wdata_q <= m_wdata_i[winner_d];
            s_req_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (s_ack_i) begin
            if (s_cmd_q) begin
              s_req_q <= 1'b0;
              state_q <= S_DROP;
            end else begin
              state_q <= S_CAP;
            end
          end
        end
        // Read data is valid one edge after ack is first seen, so reads hold s_req one extra cycle.
        S_CAP: begin
          m_rdata_q[grant_q] <= s_rdata_i;
          s_req_q            <= 1'b0;
          state_q            <= S_DROP;
        end
        S_DROP: begin
          if (!s_ack_i) begin
            m_ack_q[grant_q] <= 1'b1;
            state_q          <= S_DONE;
          end
        end
        S_DONE: begin
          if (!m_req_i[grant_q]) begin
            m_ack_q[grant_q] <= 1'b0;
            busy_q           <= 1'b0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_ack_o    = m_ack_q;
  assign m_rdata_o  = m_rdata_q;
  assign s_req_o    = s_req_q;
  assign s_cmd_o    = s_cmd_q;
  assign s_addr_o   = s_addr_q;
  assign s_wdata_o  = s_wdata_q;
  assign grant_id_o = grant_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_slave_arbiter.sv
// Bench for slave_arbiter: 4 masters, a behavioural 16-word slave, and a round-robin schedule model.
module tb_slave_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       m_req, m_cmd, m_ack;
  logic [3:0][31:0] m_addr, m_wdata, m_rdata;
  logic             s_req, s_cmd, s_ack;
  logic [31:0]      s_addr, s_wdata, s_rdata;
  logic [1:0]       grant_id;
  logic             busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] slvMem [16];
  logic [31:0] refMem [16];
  logic [31:0] expRdata [4];
  int          lastGrant;

  int          grantLog [$];
  int          expLog [$];
  int          rdWho [$];
  logic [31:0] rdObs [$];
  logic [31:0] rdExp [$];
  int          strayCnt;
  int          onehotCnt;

  slave_arbiter #(.N_MST(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .m_req_i    (m_req),
    .m_cmd_i    (m_cmd),
    .m_addr_i   (m_addr),
    .m_wdata_i  (m_wdata),
    .m_ack_o    (m_ack),
    .m_rdata_o  (m_rdata),
    .s_req_o    (s_req),
    .s_cmd_o    (s_cmd),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_ack_i    (s_ack),
    .s_rdata_i  (s_rdata),
    .grant_id_o (grant_id),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Slave: REQ -> WR (ack rises) -> RD (data valid) -> RET (ack falls once req is low).
  initial begin
    int slSt;
    slSt = 0;
    s_ack = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < 16; i++) slvMem[i] = {16'hC0DE, 12'h0, 4'(i)};
    forever begin
      @(posedge clk);
      case (slSt)
        0: if (s_req) slSt <= 1;
        1: begin s_ack <= 1'b1; slSt <= 2; end
        2: begin
          if (s_cmd) slvMem[s_addr[3:0]] <= s_wdata;
          else s_rdata <= slvMem[s_addr[3:0]];
          slSt <= 3;
        end
        default: if (!s_req) begin s_ack <= 1'b0; slSt <= 0; end
      endcase
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    m_req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lastGrant = 3;
    for (int j = 0; j < 4; j++) expRdata[j] = '0;
  endtask

  task automatic runTxn(input int m, input logic cmd, input logic [3:0] addr,
                        input logic [31:0] wd, output int lat, output int rel);
    int gEdge, aEdge, k;
    gEdge = -1; aEdge = -1; rel = -1;
    @(negedge clk);
    m_cmd[m] = cmd; m_addr[m] = {28'h0, addr}; m_wdata[m] = wd; m_req[m] = 1'b1;
    k = 0;
    while (aEdge < 0 && k < 50) begin
      @(negedge clk); k++;
      if (gEdge < 0 && busy) gEdge = k;
      if (m_ack[m]) aEdge = k;
    end
    lat = (gEdge >= 0 && aEdge >= 0) ? aEdge - gEdge : -1;
    m_req[m] = 1'b0;
    k = 0;
    while (rel < 0 && k < 20) begin
      @(negedge clk); k++;
      if (!busy && m_ack == 4'b0) rel = k;
    end
    if (aEdge >= 0) begin
      lastGrant = m;
      if (cmd) refMem[addr] = wd;
      else expRdata[m] = refMem[addr];
    end
  endtask

  // Expected grant sequence: each pending master is served in cyclic order after the last grant.
  task automatic buildSchedule(input logic [3:0] mask, input int perM);
    int left [4];
    int cnt, last;
    expLog.delete();
    cnt = 0; last = lastGrant;
    for (int j = 0; j < 4; j++) begin left[j] = mask[j] ? perM : 0; cnt += left[j]; end
    for (int n = 0; n < cnt; n++) begin
      for (int k = 1; k <= 4; k++) begin
        if (left[(last + k) % 4] > 0) begin
          last = (last + k) % 4;
          left[last]--;
          expLog.push_back(last);
          break;
        end
      end
    end
    lastGrant = last;
  endtask

  task automatic loadCmd(input int j, input logic anyWrite);
    m_cmd[j]   = anyWrite ? 1'($urandom_range(0, 1)) : 1'b0;
    m_addr[j]  = $urandom_range(0, 15);
    m_wdata[j] = $urandom;
  endtask

  // Masters in mask request together; each re-requests after its ack falls until perM are served.
  task automatic runContention(input logic [3:0] mask, input int perM, input logic anyWrite,
                               output logic timedOut);
    int remaining [4];
    logic [3:0] prevAck;
    logic prevBusy, stray;
    int curG;
    grantLog.delete(); rdWho.delete(); rdObs.delete(); rdExp.delete();
    strayCnt = 0; onehotCnt = 0; timedOut = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      remaining[j] = mask[j] ? perM : 0;
      if (mask[j]) begin loadCmd(j, anyWrite); m_req[j] = 1'b1; end
    end
    prevAck = m_ack; prevBusy = busy;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (busy && !prevBusy) grantLog.push_back(int'(grant_id));
      curG = (busy && grantLog.size() > 0) ? grantLog[grantLog.size()-1] : -1;
      if ($countones(m_ack) > 1) onehotCnt++;
      stray = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (m_ack[j] && !prevAck[j]) begin
          if (m_cmd[j]) refMem[m_addr[j][3:0]] = m_wdata[j];
          else begin
            rdWho.push_back(j);
            rdObs.push_back(m_rdata[j]);
            rdExp.push_back(refMem[m_addr[j][3:0]]);
            expRdata[j] = refMem[m_addr[j][3:0]];
          end
          remaining[j]--;
          m_req[j] = 1'b0;
        end else if (!m_ack[j] && prevAck[j] && remaining[j] > 0) begin
          loadCmd(j, anyWrite);
          m_req[j] = 1'b1;
        end
        if (j != curG && m_rdata[j] !== expRdata[j]) stray = 1'b1;
      end
      if (stray) strayCnt++;
      prevAck = m_ack; prevBusy = busy;
      if (remaining[0] + remaining[1] + remaining[2] + remaining[3] == 0 && !busy && m_ack == 4'b0) begin
        timedOut = 1'b0;
        break;
      end
    end
    m_req = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (m_ack !== 4'b0) begin bad++; $display("[TB] FAIL rst_m_ack: got %h expected 0", m_ack); end
    total++; if (s_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_s_req: got %b expected 0", s_req); end
    total++; if ({s_cmd, s_addr, s_wdata} !== 65'b0) begin bad++; $display("[TB] FAIL rst_s_bus: got %b/%h/%h expected 0", s_cmd, s_addr, s_wdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    total++; if (grant_id !== 2'd3) begin bad++; $display("[TB] FAIL rst_grant: got %0d expected 3", grant_id); end
    total++; if (m_rdata !== '0) begin bad++; $display("[TB] FAIL rst_rdata: got %h expected 0", m_rdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || s_req !== 1'b0) begin bad++; $display("[TB] FAIL idle_no_req: got busy=%b s_req=%b expected 0/0", busy, s_req); end
  endtask

  task automatic test_write_read();
    int lat, rel;
    runTxn(2, 1'b1, 4'd5, 32'hDEADBEEF, lat, rel);
    total++; if (lat !== 5) begin bad++; $display("[TB] FAIL wr_latency: got %0d expected 5", lat); end
    total++; if (rel !== 1) begin bad++; $display("[TB] FAIL wr_release: got %0d expected 1", rel); end
    runTxn(2, 1'b0, 4'd5, 32'h0, lat, rel);
    total++; if (lat !== 6) begin bad++; $display("[TB] FAIL rd_latency: got %0d expected 6", lat); end
    total++; if (rel !== 1) begin bad++; $display("[TB] FAIL rd_release: got %0d expected 1", rel); end
    total++; if (m_rdata[2] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rd_data: got %h expected deadbeef", m_rdata[2]); end
    for (int j = 0; j < 4; j++) begin
      if (j == 2) continue;
      total++; if (m_rdata[j] !== expRdata[j]) begin bad++; $display("[TB] FAIL rd_other%0d: got %h expected %h", j, m_rdata[j], expRdata[j]); end
    end
  endtask

  task automatic test_all_masters();
    logic to;
    doReset();
    buildSchedule(4'hF, 1);
    runContention(4'hF, 1, 1'b0, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL all_timeout: got %b expected 0", to); end
    total++; if (grantLog.size() !== expLog.size()) begin bad++; $display("[TB] FAIL all_count: got %0d expected %0d", grantLog.size(), expLog.size()); end
    for (int i = 0; i < expLog.size(); i++) begin
      total++;
      if (i >= grantLog.size() || grantLog[i] !== expLog[i]) begin
        bad++; $display("[TB] FAIL all_order%0d: got %0d expected %0d", i, (i < grantLog.size()) ? grantLog[i] : -1, expLog[i]);
      end
    end
    for (int i = 0; i < rdObs.size(); i++) begin
      total++; if (rdObs[i] !== rdExp[i]) begin bad++; $display("[TB] FAIL all_rdata_m%0d: got %h expected %h", rdWho[i], rdObs[i], rdExp[i]); end
    end
    total++; if (strayCnt !== 0) begin bad++; $display("[TB] FAIL all_stray: got %0d expected 0", strayCnt); end
    total++; if (onehotCnt !== 0) begin bad++; $display("[TB] FAIL all_onehot: got %0d expected 0", onehotCnt); end
  endtask

  task automatic test_fairness();
    logic to;
    int wrong;
    buildSchedule(4'b1010, 3);
    runContention(4'b1010, 3, 1'b0, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL fair_timeout: got %b expected 0", to); end
    total++; if (grantLog.size() !== 6) begin bad++; $display("[TB] FAIL fair_count: got %0d expected 6", grantLog.size()); end
    wrong = 0;
    for (int i = 0; i < grantLog.size(); i++) if (grantLog[i] == 0 || grantLog[i] == 2) wrong++;
    total++; if (wrong !== 0) begin bad++; $display("[TB] FAIL fair_idle_masters: got %0d grants to 0/2 expected 0", wrong); end
    for (int i = 0; i < expLog.size() && i < grantLog.size(); i++) begin
      total++; if (grantLog[i] !== expLog[i]) begin bad++; $display("[TB] FAIL fair_order%0d: got %0d expected %0d", i, grantLog[i], expLog[i]); end
    end
    total++; if (strayCnt !== 0) begin bad++; $display("[TB] FAIL fair_stray: got %0d expected 0", strayCnt); end
  endtask

  task automatic test_drop_before_grant();
    int k, g2;
    logic saw0, done3, prevBusy;
    logic [3:0] a3;
    logic [31:0] obs3, exp3;
    @(negedge clk);
    m_cmd[1] = 1'b1; m_addr[1] = 32'd3; m_wdata[1] = $urandom; m_req[1] = 1'b1;
    @(negedge clk);
    total++; if (grant_id !== 2'd1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL drop_first_grant: got %0d/%b expected 1/1", grant_id, busy); end
    a3 = 4'($urandom_range(0, 15));
    m_cmd[0] = 1'b0; m_addr[0] = 32'd9; m_req[0] = 1'b1;
    m_cmd[3] = 1'b0; m_addr[3] = {28'h0, a3}; m_req[3] = 1'b1;
    @(negedge clk);
    m_req[0] = 1'b0;
    saw0 = 1'b0; done3 = 1'b0; g2 = -1; prevBusy = 1'b1; k = 0; obs3 = '0; exp3 = '1;
    while (!done3 && k < 60) begin
      @(negedge clk); k++;
      if (m_ack[0]) saw0 = 1'b1;
      if (m_ack[1] && m_req[1]) begin m_req[1] = 1'b0; refMem[3] = m_wdata[1]; end
      if (busy && !prevBusy && g2 < 0) g2 = int'(grant_id);
      if (m_ack[3]) begin obs3 = m_rdata[3]; exp3 = refMem[a3]; m_req[3] = 1'b0; done3 = 1'b1; end
      prevBusy = busy;
    end
    k = 0;
    while ((busy || m_ack != 4'b0) && k < 20) begin @(negedge clk); k++; if (m_ack[0]) saw0 = 1'b1; end
    lastGrant = 3; expRdata[3] = exp3;
    total++; if (g2 !== 3) begin bad++; $display("[TB] FAIL drop_next_grant: got %0d expected 3", g2); end
    total++; if (saw0 !== 1'b0) begin bad++; $display("[TB] FAIL drop_m0_ack: got %b expected 0", saw0); end
    total++; if (done3 !== 1'b1 || obs3 !== exp3) begin bad++; $display("[TB] FAIL drop_m3_rdata: got %h expected %h", obs3, exp3); end
  endtask

  task automatic test_drop_during_wait();
    int k, ackCycles;
    @(negedge clk);
    m_cmd[0] = 1'b1; m_addr[0] = 32'd7; m_wdata[0] = 32'h12345678; m_req[0] = 1'b1;
    k = 0;
    while (!busy && k < 10) begin @(negedge clk); k++; end
    m_req[0] = 1'b0;
    ackCycles = 0; k = 0;
    while (busy && k < 30) begin
      @(negedge clk); k++;
      if (m_ack[0]) ackCycles++;
    end
    refMem[7] = 32'h12345678; lastGrant = 0;
    total++; if (slvMem[7] !== 32'h12345678) begin bad++; $display("[TB] FAIL viol_mem: got %h expected 12345678", slvMem[7]); end
    total++; if (ackCycles !== 1) begin bad++; $display("[TB] FAIL viol_ack_pulse: got %0d expected 1", ackCycles); end
    total++; if (busy !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("[TB] FAIL viol_idle: got busy=%b grant=%0d expected 0/0", busy, grant_id); end
  endtask

  task automatic test_reset_mid();
    int k, lat, rel;
    logic [3:0] a;
    logic [31:0] wd;
    @(negedge clk);
    m_cmd[1] = 1'b0; m_addr[1] = 32'd2; m_req[1] = 1'b1;
    k = 0;
    while (!busy && k < 10) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    total++; if (s_req !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_sreq: got %b expected 1", s_req); end
    rst_n = 1'b0;
    #1;
    total++; if (s_req !== 1'b0) begin bad++; $display("[TB] FAIL mid_s_req: got %b expected 0", s_req); end
    total++; if (m_ack !== 4'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_ack_busy: got %h/%b expected 0/0", m_ack, busy); end
    total++; if (grant_id !== 2'd3) begin bad++; $display("[TB] FAIL mid_grant: got %0d expected 3", grant_id); end
    total++; if (m_rdata !== '0) begin bad++; $display("[TB] FAIL mid_rdata: got %h expected 0", m_rdata); end
    m_req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lastGrant = 3;
    for (int j = 0; j < 4; j++) expRdata[j] = '0;
    a = 4'($urandom_range(0, 15));
    wd = $urandom;
    runTxn(1, 1'b1, a, wd, lat, rel);
    total++; if (lat !== 5) begin bad++; $display("[TB] FAIL mid_wr_latency: got %0d expected 5", lat); end
    runTxn(1, 1'b0, a, 32'h0, lat, rel);
    total++; if (lat !== 6) begin bad++; $display("[TB] FAIL mid_rd_latency: got %0d expected 6", lat); end
    total++; if (m_rdata[1] !== wd) begin bad++; $display("[TB] FAIL mid_rd_data: got %h expected %h", m_rdata[1], wd); end
  endtask

  task automatic test_random();
    logic to;
    logic [3:0] mask;
    for (int r = 0; r < 3; r++) begin
      mask = 4'($urandom_range(1, 15));
      buildSchedule(mask, 2);
      runContention(mask, 2, 1'b1, to);
      total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_timeout: got %b expected 0", r, to); end
      total++; if (grantLog.size() !== expLog.size()) begin bad++; $display("[TB] FAIL rnd%0d_count: got %0d expected %0d", r, grantLog.size(), expLog.size()); end
      for (int i = 0; i < expLog.size() && i < grantLog.size(); i++) begin
        total++; if (grantLog[i] !== expLog[i]) begin bad++; $display("[TB] FAIL rnd%0d_order%0d: got %0d expected %0d", r, i, grantLog[i], expLog[i]); end
      end
      for (int i = 0; i < rdObs.size(); i++) begin
        total++; if (rdObs[i] !== rdExp[i]) begin bad++; $display("[TB] FAIL rnd%0d_rdata_m%0d: got %h expected %h", r, rdWho[i], rdObs[i], rdExp[i]); end
      end
      total++; if (strayCnt !== 0 || onehotCnt !== 0) begin bad++; $display("[TB] FAIL rnd%0d_stray_onehot: got %0d/%0d expected 0/0", r, strayCnt, onehotCnt); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    lastGrant = 3;
    for (int i = 0; i < 16; i++) refMem[i] = {16'hC0DE, 12'h0, 4'(i)};
    for (int j = 0; j < 4; j++) expRdata[j] = '0;
    test_reset();
    test_write_read();
    test_all_masters();
    test_fairness();
    test_drop_before_grant();
    test_drop_during_wait();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slave_arbiter.md
# slave_arbiter

Round-robin arbiter sharing one single-port memory slave (4-phase req/ack, 16 × 32-bit words) among N_MST masters. It latches the winning master's command, runs the full 4-phase handshake on the slave side, and captures read data at the correct cycle. It then completes a separate 4-phase handshake back to the granted master. It sits between the master bank and the slave; the slave keeps its existing protocol unchanged.

## Interface
- N_MST, default 4, number of masters (2..8)
- GW, derived $clog2(N_MST), grant index width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_req  in  [N_MST]  per-master request, level, 4-phase
- m_cmd  in  [N_MST]  per-master command: 1 = write, 0 = read
- m_addr  in  [N_MST][32]  per-master word address
- m_wdata  in  [N_MST][32]  per-master write data
- m_ack  out  [N_MST]  per-master acknowledge
- m_rdata  out  [N_MST][32]  per-master read data, held until that master's next read
- s_req  out  1  slave request
- s_cmd  out  1  slave command
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_ack  in  1  slave acknowledge
- s_rdata  in  32  slave read data
- grant_id  out  GW  index of current or last granted master
- busy  out  1  high in any state other than IDLE

## Operation
- Reset values (async, rst_n low): state IDLE; m_ack = 0; m_rdata = 0; s_req = 0; s_cmd = 0; s_addr = 0; s_wdata = 0; busy = 0; grant_id = N_MST-1, so master 0 has first priority.
- Arbitration happens only in IDLE. Candidates are m_req bits sampled at that edge. Search order is grant_id+1, grant_id+2, … mod N_MST; the first set bit wins. Ties cannot starve a master.
- On grant: grant_id <= winner; s_cmd/s_addr/s_wdata <= winner's m_cmd/m_addr/m_wdata; s_req <= 1; go to S_WAIT.
- The s_cmd/s_addr/s_wdata latches stay stable from grant until the next grant. The slave re-reads the address after acknowledging.
- S_WAIT: wait for s_ack == 1.
  - Write: s_req <= 0; go to S_DROP.
  - Read: go to S_CAP.
- S_CAP (one cycle): m_rdata[grant_id] <= s_rdata; s_req <= 0; go to S_DROP. Slave read data is valid at the edge after the one at which s_ack is first sampled high.
- S_DROP: wait for s_ack == 0, then m_ack[grant_id] <= 1; go to S_DONE.
- S_DONE: wait for m_req[grant_id] == 0, then m_ack[grant_id] <= 0; go to IDLE.
- At most one m_ack bit is high at any time. m_rdata of non-granted masters never changes.
- Non-granted masters may raise or drop m_req freely. Dropping before grant means the request is never served.
- Granted master dropping m_req before m_ack (protocol violation): the slave transaction still completes. m_ack then pulses for exactly one cycle, because S_DONE sees m_req low immediately.
- Reset mid-transaction: all state clears at once and s_req drops. The slave is then allowed to finish its own RET→REQ return when it sees s_req low.

## Timing
Edge 0 is the IDLE edge that samples m_req and grants. The slave responds as REQ→WR (ack rises) → RD (read data) → RET (ack falls on !req).
- Write: s_req high after edge 0; slave ack rises after edge 2; s_req low after edge 3; ack low after edge 4; m_ack high after edge 5.
- Read: same through edge 2; S_CAP captures at edge 4; s_req low after edge 4; ack low after edge 5; m_ack high after edge 6.
- The master drops req and m_ack falls one edge after m_req is sampled low. IDLE can grant again on the following edge, so the minimum back-to-back spacing is 1 idle cycle between transactions.
- busy is high from edge 0 until the edge returning to IDLE.

## Test plan
- Single write then read, master 2: write addr 5, data 0xDEADBEEF, then read addr 5.
  - Write: m_ack[2] rises 5 cycles after grant.
  - Read: m_ack[2] rises 6 cycles after grant; m_rdata[2] = 0xDEADBEEF.
- All 4 masters request reads simultaneously after reset.
  - Grant order is 0, 1, 2, 3; each m_rdata holds its own address's word; the others stay unchanged.
- Round-robin fairness: masters 1 and 3 hold req continuously, re-requesting after each ack.
  - Grants alternate 1, 3, 1, 3; grant_id is never 0 or 2.
- Master 0 drops m_req before being granted while master 1 is being served.
  - Next grant goes to the next requester; master 0 gets no m_ack.
- Granted master drops m_req during S_WAIT on a write of 0x12345678 to addr 7.
  - Slave memory[7] = 0x12345678; m_ack pulses for 1 cycle; arbiter returns to IDLE.
- Assert rst_n low in S_CAP during a read.
  - s_req, m_ack and busy go 0 immediately (asynchronously); grant_id = N_MST-1.
  - After release, a fresh write/read completes with the nominal latencies.
